// File: rtl/coprocessor0_params.sv
// Shared CP0 definitions for the exception path.
//   exc_code_e    : architectural ExcCode values used by the sequencer
//   event_kind_e  : kind of CP0 update command (none / exception / ERET)
//   cp0_event_t   : latched event record driven onto the CP0 update command
//   has_bad_vaddr : true for address-error codes that carry a BadVAddr
package coprocessor0_params;

   typedef enum logic [4:0] {
      ExcInt  = 5'd0,
      ExcAdel = 5'd4,
      ExcAdes = 5'd5,
      ExcSys  = 5'd8,
      ExcBp   = 5'd9,
      ExcRi   = 5'd10,
      ExcOv   = 5'd12
   } exc_code_e;

   typedef enum logic [1:0] {
      EvNone = 2'd0,
      EvExc  = 2'd1,
      EvEret = 2'd2
   } event_kind_e;

   typedef struct packed {
      event_kind_e kind;
      logic [4:0]  exc_code;
      logic        bd;
      logic [31:0] epc;
      logic [31:0] bad_vaddr;
   } cp0_event_t;

   function automatic logic has_bad_vaddr(input logic [4:0] code);
      return (code == 5'(ExcAdel)) || (code == 5'(ExcAdes));
   endfunction

endpackage

// File: rtl/exception_sequencer.sv
// Exception / interrupt / ERET sequencer sitting behind the WB stage.
// On a committing instruction that raises an event it flushes the pipe in the
// same cycle, issues a one-cycle CP0 update command, then holds a fetch
// redirect until fetch accepts it.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   wb_*                      : committing instruction and its exception info
//   cp0_status_*, cp0_cause_ip, cp0_epc : current CP0 state
//   cp0_event_*               : CP0 update command (valid for one cycle)
//   flush, wb_stall           : pipeline control
//   redirect_valid/pc/ready   : fetch-redirect handshake
module exception_sequencer
   import coprocessor0_params::*;
#(
   parameter logic [31:0] EXCEPTION_ENTRY = 32'hbfc00380
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic [31:0] wb_pc,
   input  logic        wb_in_delay_slot,
   input  logic        wb_exception,
   input  logic [4:0]  wb_exc_code,
   input  logic [31:0] wb_bad_vaddr,
   input  logic        wb_eret,
   input  logic        cp0_status_ie,
   input  logic        cp0_status_exl,
   input  logic [7:0]  cp0_status_im,
   input  logic [7:0]  cp0_cause_ip,
   input  logic [31:0] cp0_epc,
   output logic        cp0_event_valid,
   output logic [1:0]  cp0_event_kind,
   output logic [4:0]  cp0_event_exc_code,
   output logic        cp0_event_bd,
   output logic [31:0] cp0_event_epc,
   output logic [31:0] cp0_event_bad_vaddr,
   output logic        flush,
   output logic        wb_stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready
);

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StWriteCp0 = 2'd1;
   localparam logic [1:0] StRedirect = 2'd2;

   logic [1:0]  state_q, state_d;
   cp0_event_t  ev_q, ev_d;
   logic [31:0] target_q, target_d;
   // Blocks event take for one cycle after reset and after a completed redirect.
   logic        hold_off_q;

   logic        irq_pending;
   logic        take;
   logic [4:0]  exc_code;

   assign irq_pending = (|(cp0_cause_ip & cp0_status_im)) & cp0_status_ie & ~cp0_status_exl;
   assign take        = (state_q == StIdle) & ~hold_off_q & ~reset & wb_valid &
                        (irq_pending | wb_exception | wb_eret);
   assign exc_code    = irq_pending ? 5'(ExcInt) : wb_exc_code;

   always_comb begin
      state_d  = state_q;
      ev_d     = ev_q;
      target_d = target_q;
      case (state_q)
         StIdle: begin
            if (take) begin
               state_d = StWriteCp0;
               if (irq_pending || wb_exception) begin
                  ev_d.kind      = EvExc;
                  ev_d.exc_code  = exc_code;
                  ev_d.bd        = wb_in_delay_slot;
                  // Delay-slot faults restart at the branch.
                  ev_d.epc       = wb_in_delay_slot ? (wb_pc - 32'd4) : wb_pc;
                  ev_d.bad_vaddr = has_bad_vaddr(exc_code) ? wb_bad_vaddr : 32'd0;
                  target_d       = EXCEPTION_ENTRY;
               end else begin
                  ev_d.kind      = EvEret;
                  ev_d.exc_code  = 5'd0;
                  ev_d.bd        = 1'b0;
                  ev_d.epc       = 32'd0;
                  ev_d.bad_vaddr = 32'd0;
                  target_d       = cp0_epc;
               end
            end
         end
         StWriteCp0: state_d = StRedirect;
         StRedirect: if (redirect_ready) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         ev_q       <= '0;
         target_q   <= 32'd0;
         hold_off_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         ev_q       <= ev_d;
         target_q   <= target_d;
         hold_off_q <= (state_q == StRedirect) & redirect_ready;
      end
   end

   // Outputs are gated by reset so a mid-sequence reset silences them at once.
   always_comb begin
      flush           = take;
      wb_stall        = ~reset & (state_q != StIdle);
      cp0_event_valid = ~reset & (state_q == StWriteCp0);
      redirect_valid  = ~reset & (state_q == StRedirect);

      cp0_event_kind      = 2'd0;
      cp0_event_exc_code  = 5'd0;
      cp0_event_bd        = 1'b0;
      cp0_event_epc       = 32'd0;
      cp0_event_bad_vaddr = 32'd0;
      if (cp0_event_valid) begin
         cp0_event_kind      = ev_q.kind;
         cp0_event_exc_code  = ev_q.exc_code;
         cp0_event_bd        = ev_q.bd;
         cp0_event_epc       = ev_q.epc;
         cp0_event_bad_vaddr = ev_q.bad_vaddr;
      end
      redirect_pc = redirect_valid ? target_q : 32'd0;
   end

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench for exception_sequencer: the driver pushes expected CP0
// commands and redirects when it issues an event; a negedge monitor pops and
// compares whenever the DUT presents one.
module tb_exception_sequencer;
   import coprocessor0_params::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        wb_valid, wb_in_delay_slot, wb_exception, wb_eret;
   logic [31:0] wb_pc, wb_bad_vaddr;
   logic [4:0]  wb_exc_code;
   logic        cp0_status_ie, cp0_status_exl;
   logic [7:0]  cp0_status_im, cp0_cause_ip;
   logic [31:0] cp0_epc;
   logic        cp0_event_valid, cp0_event_bd;
   logic [1:0]  cp0_event_kind;
   logic [4:0]  cp0_event_exc_code;
   logic [31:0] cp0_event_epc, cp0_event_bad_vaddr;
   logic        flush, wb_stall, redirect_valid, redirect_ready;
   logic [31:0] redirect_pc;

   always #5 clock = ~clock;

   exception_sequencer #(.EXCEPTION_ENTRY(32'hbfc00380)) dut (
      .clock(clock), .reset(reset),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_in_delay_slot(wb_in_delay_slot),
      .wb_exception(wb_exception), .wb_exc_code(wb_exc_code), .wb_bad_vaddr(wb_bad_vaddr),
      .wb_eret(wb_eret),
      .cp0_status_ie(cp0_status_ie), .cp0_status_exl(cp0_status_exl),
      .cp0_status_im(cp0_status_im), .cp0_cause_ip(cp0_cause_ip), .cp0_epc(cp0_epc),
      .cp0_event_valid(cp0_event_valid), .cp0_event_kind(cp0_event_kind),
      .cp0_event_exc_code(cp0_event_exc_code), .cp0_event_bd(cp0_event_bd),
      .cp0_event_epc(cp0_event_epc), .cp0_event_bad_vaddr(cp0_event_bad_vaddr),
      .flush(flush), .wb_stall(wb_stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready)
   );

   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  code;
      logic        bd;
      logic [31:0] epc;
      logic [31:0] bad;
      int          cyc;
   } exp_ev_t;

   typedef struct {
      logic [31:0] pc;
      int          cyc;
   } exp_rd_t;

   exp_ev_t ev_sb[$];
   exp_rd_t rd_sb[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor
   exp_ev_t     mon_ev;
   exp_rd_t     mon_rd;
   logic        rv_prev = 1'b0;
   logic [31:0] pc_prev = 32'd0;

   always @(negedge clock) begin
      if (cp0_event_valid) begin
         if (ev_sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cp0_event: got code %0d epc %h want none",
                     cp0_event_exc_code, cp0_event_epc);
         end else begin
            mon_ev = ev_sb.pop_front();
            check("ev_kind", 32'(cp0_event_kind), 32'(mon_ev.kind));
            check("ev_code", 32'(cp0_event_exc_code), 32'(mon_ev.code));
            check("ev_bd", 32'(cp0_event_bd), 32'(mon_ev.bd));
            check("ev_epc", cp0_event_epc, mon_ev.epc);
            check("ev_bad_vaddr", cp0_event_bad_vaddr, mon_ev.bad);
            check("ev_latency", 32'(cyc), 32'(mon_ev.cyc));
            check("ev_stall", 32'(wb_stall), 32'd1);
         end
      end
      if (redirect_valid) begin
         if (!rv_prev) begin
            if (rd_sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_redirect: got pc %h want none", redirect_pc);
            end else begin
               mon_rd = rd_sb.pop_front();
               check("redirect_pc", redirect_pc, mon_rd.pc);
               check("redirect_latency", 32'(cyc), 32'(mon_rd.cyc));
            end
         end else begin
            check("redirect_pc_stable", redirect_pc, pc_prev);
         end
         check("redirect_stall", 32'(wb_stall), 32'd1);
      end
      rv_prev = redirect_valid;
      pc_prev = redirect_pc;
   end

   // Driver helpers
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_wb();
      wb_valid = 0; wb_exception = 0; wb_eret = 0; wb_in_delay_slot = 0;
      wb_pc = 0; wb_exc_code = 0; wb_bad_vaddr = 0;
   endtask

   task automatic check_quiet(input string name);
      check({name, "_flush"}, 32'(flush), 32'd0);
      check({name, "_stall"}, 32'(wb_stall), 32'd0);
      check({name, "_ev_valid"}, 32'(cp0_event_valid), 32'd0);
      check({name, "_rd_valid"}, 32'(redirect_valid), 32'd0);
      check({name, "_rd_pc"}, redirect_pc, 32'd0);
      check({name, "_ev_epc"}, cp0_event_epc, 32'd0);
   endtask

   // Present an event at posedge+1 and record what must follow.
   task automatic issue(input string name, input logic exc, input logic eret,
                        input logic [4:0] code, input logic [31:0] pc, input logic ds,
                        input logic [31:0] bv, input logic [1:0] k, input logic [4:0] ec,
                        input logic eb, input logic [31:0] eepc, input logic [31:0] ebad,
                        input logic [31:0] rpc);
      exp_ev_t e;
      exp_rd_t r;
      wb_valid = 1; wb_exception = exc; wb_eret = eret; wb_exc_code = code;
      wb_pc = pc; wb_in_delay_slot = ds; wb_bad_vaddr = bv;
      #1;
      check({name, "_flush"}, 32'(flush), 32'd1);
      e.kind = k; e.code = ec; e.bd = eb; e.epc = eepc; e.bad = ebad; e.cyc = cyc + 1;
      r.pc = rpc; r.cyc = cyc + 2;
      ev_sb.push_back(e);
      rd_sb.push_back(r);
   endtask

   task automatic wait_idle(input string name);
      bit done = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!wb_stall && !redirect_valid) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got stalled after 20 cycles want idle", name);
      end
   endtask

   task automatic finish_event(input string name);
      step();
      clear_wb();
      wait_idle(name);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1; redirect_ready = 1;
      clear_wb();
      cp0_status_ie = 0; cp0_status_exl = 0; cp0_status_im = 0; cp0_cause_ip = 0;
      cp0_epc = 0;
      step();
      step();
      // Event presented under reset must not be taken.
      wb_valid = 1; wb_exception = 1; wb_exc_code = 5'd12; wb_pc = 32'h100;
      #1;
      check_quiet("in_reset");
      step();
      reset = 0;
      #1;
      check_quiet("after_reset");
      step();
      clear_wb();

      // Plain exception, no delay slot.
      issue("ov", 1, 0, 5'd12, 32'hbfc00100, 0, 32'hdead, 2'd1, 5'd12, 0, 32'hbfc00100,
            32'd0, 32'hbfc00380);
      finish_event("ov");

      // Address error in a delay slot.
      issue("adel_ds", 1, 0, 5'd4, 32'h80000008, 1, 32'h1235, 2'd1, 5'd4, 1, 32'h80000004,
            32'h1235, 32'hbfc00380);
      finish_event("adel_ds");

      // Interrupt beats a simultaneous syscall.
      cp0_status_ie = 1; cp0_status_exl = 0; cp0_status_im = 8'h04; cp0_cause_ip = 8'h04;
      issue("irq_wins", 1, 0, 5'd8, 32'h80000100, 0, 32'h55, 2'd1, 5'd0, 0, 32'h80000100,
            32'd0, 32'hbfc00380);
      finish_event("irq_wins");

      // EXL masks the interrupt, syscall proceeds.
      cp0_status_exl = 1;
      issue("exl_mask", 1, 0, 5'd8, 32'h80000100, 0, 32'h55, 2'd1, 5'd8, 0, 32'h80000100,
            32'd0, 32'hbfc00380);
      finish_event("exl_mask");

      // wb_valid low: nothing taken even with everything pending.
      cp0_status_exl = 0;
      wb_valid = 0; wb_exception = 1; wb_eret = 1; wb_exc_code = 5'd12;
      #1;
      check("no_valid_flush", 32'(flush), 32'd0);
      step();
      check("no_valid_stall", 32'(wb_stall), 32'd0);
      clear_wb();
      cp0_status_ie = 0;
      step();

      // ERET with fetch stalled for three redirect cycles.
      cp0_epc = 32'h80001000;
      redirect_ready = 0;
      issue("eret", 0, 1, 5'd0, 32'h1234, 1, 32'h99, 2'd2, 5'd0, 0, 32'd0, 32'd0,
            32'h80001000);
      step();
      cp0_epc = 32'h11111111;
      wb_eret = 0; wb_exception = 1; wb_exc_code = 5'd12;
      check("eret_wcp0_noflush", 32'(flush), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("eret_hold_valid", 32'(redirect_valid), 32'd1);
         check("eret_hold_noflush", 32'(flush), 32'd0);
      end
      redirect_ready = 1;
      step();
      // Return cycle: the held exception must be ignored.
      check("eret_return_noflush", 32'(flush), 32'd0);
      check("eret_return_stall", 32'(wb_stall), 32'd0);
      clear_wb();
      step();

      // Reset in the middle of a redirect handshake.
      redirect_ready = 0;
      issue("ri", 1, 0, 5'd10, 32'h80000200, 0, 32'd0, 2'd1, 5'd10, 0, 32'h80000200,
            32'd0, 32'hbfc00380);
      step();
      clear_wb();
      step();
      step();
      check("pre_reset_rd_valid", 32'(redirect_valid), 32'd1);
      reset = 1;
      #1;
      check_quiet("mid_reset");
      step();
      reset = 0;
      redirect_ready = 1;
      wb_valid = 1; wb_exception = 1; wb_exc_code = 5'd9; wb_pc = 32'h80000300;
      #1;
      check_quiet("post_reset");
      step();
      issue("bp_after_reset", 1, 0, 5'd9, 32'h80000300, 0, 32'd0, 2'd1, 5'd9, 0,
            32'h80000300, 32'd0, 32'hbfc00380);
      finish_event("bp_after_reset");

      // Back-to-back: event held into the return cycle is ignored.
      issue("b2b_first", 1, 0, 5'd12, 32'h80000400, 0, 32'd0, 2'd1, 5'd12, 0, 32'h80000400,
            32'd0, 32'hbfc00380);
      step();
      step();
      step();
      check("b2b_return_noflush", 32'(flush), 32'd0);
      check("b2b_return_stall", 32'(wb_stall), 32'd0);
      step();
      issue("wrap_ds", 1, 0, 5'd12, 32'h00000000, 1, 32'd0, 2'd1, 5'd12, 1, 32'hfffffffc,
            32'd0, 32'hbfc00380);
      finish_event("wrap_ds");

      step();
      step();
      check("ev_sb_drained", 32'(ev_sb.size()), 32'd0);
      check("rd_sb_drained", 32'(rd_sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
